// File: rtl/ub_pkg.sv
// Shared types and constants for the unified-buffer FIFO bridge.
package ub_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RD,
    ST_CAP,
    ST_OUT,
    ST_FINISH
  } ub_bridge_state_t;

  localparam logic UB_DIR_LOAD   = 1'b0;
  localparam logic UB_DIR_DRAIN  = 1'b1;
  localparam logic UB_SECTION_LO = 1'b0;
  localparam logic UB_SECTION_HI = 1'b1;

endpackage

// File: rtl/ub_addr_seq.sv
// Word/byte sequencer: tracks base, word index, byte select and remaining bytes,
// and produces the wrapped buffer address for both the current and next step.
module ub_addr_seq
  import ub_pkg::*;
#(
  parameter int BUFFER_SIZE  = 1024,
  parameter int ADDRESS_SIZE = $clog2(BUFFER_SIZE)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic                    adv,
  input  logic [ADDRESS_SIZE-1:0] base_in,
  input  logic [ADDRESS_SIZE:0]   words_in,
  output logic [ADDRESS_SIZE-1:0] addr,
  output logic                    section,
  output logic [ADDRESS_SIZE-1:0] addr_nxt,
  output logic                    section_nxt,
  output logic                    last
);

  localparam int CW = ADDRESS_SIZE + 2;
  localparam logic [CW-1:0]         BS_C = CW'(BUFFER_SIZE);
  localparam logic [ADDRESS_SIZE:0] BS_W = (ADDRESS_SIZE+1)'(BUFFER_SIZE);

  logic [ADDRESS_SIZE-1:0] base_q, base_d;
  logic [ADDRESS_SIZE:0]   idx_q, idx_d, words_sat;
  logic                    sel_q, sel_d;
  logic [CW-1:0]           rem_q, rem_d;

  // base may exceed BUFFER_SIZE when it is not a power of two, so up to two folds
  function automatic logic [ADDRESS_SIZE-1:0] wrap(input logic [ADDRESS_SIZE-1:0] b,
                                                   input logic [ADDRESS_SIZE:0]   i);
    logic [CW-1:0] s;
    s = {2'b00, b} + {1'b0, i};
    if (s >= BS_C) s = s - BS_C;
    if (s >= BS_C) s = s - BS_C;
    return s[ADDRESS_SIZE-1:0];
  endfunction

  assign words_sat = (words_in > BS_W) ? BS_W : words_in;

  always_comb begin
    base_d = base_q;
    idx_d  = idx_q;
    sel_d  = sel_q;
    rem_d  = rem_q;
    if (load) begin
      base_d = base_in;
      idx_d  = '0;
      sel_d  = UB_SECTION_LO;
      rem_d  = {words_sat, 1'b0};
    end else if (adv) begin
      sel_d = ~sel_q;
      idx_d = (sel_q == UB_SECTION_HI) ? idx_q + (ADDRESS_SIZE+1)'(1) : idx_q;
      rem_d = rem_q - CW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      base_q <= '0;
      idx_q  <= '0;
      sel_q  <= UB_SECTION_LO;
      rem_q  <= '0;
    end else begin
      base_q <= base_d;
      idx_q  <= idx_d;
      sel_q  <= sel_d;
      rem_q  <= rem_d;
    end
  end

  assign addr        = wrap(base_q, idx_q);
  assign section     = sel_q;
  assign addr_nxt    = wrap(base_d, idx_d);
  assign section_nxt = sel_d;
  assign last        = (rem_q == CW'(1));

endmodule

// File: rtl/ub_fifo_bridge.sv
// Host-stream bridge to the unified buffer's byte FIFO port: loads byte streams
// into 16-bit words (low byte first) and drains words back out as bytes.
module ub_fifo_bridge
  import ub_pkg::*;
#(
  parameter int BUFFER_SIZE     = 1024,
  parameter int FIFO_DATA_WIDTH = 8,
  parameter int ADDRESS_SIZE    = $clog2(BUFFER_SIZE)
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       cmd_valid,
  output logic                       cmd_ready,
  input  logic                       cmd_dir,
  input  logic [ADDRESS_SIZE-1:0]    cmd_base,
  input  logic [ADDRESS_SIZE:0]      cmd_words,
  output logic                       cmd_done,
  output logic                       busy,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [FIFO_DATA_WIDTH-1:0] in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [FIFO_DATA_WIDTH-1:0] out_data,
  output logic                       ub_we,
  output logic                       ub_re,
  output logic                       ub_fifo_en,
  output logic                       ub_section,
  output logic [ADDRESS_SIZE-1:0]    ub_address,
  output logic [FIFO_DATA_WIDTH-1:0] ub_fifo_in,
  input  logic [FIFO_DATA_WIDTH-1:0] ub_fifo_out
);

  ub_bridge_state_t state, state_nxt;

  logic [ADDRESS_SIZE-1:0] seq_addr, seq_addr_nxt;
  logic                    seq_sec, seq_sec_nxt, seq_last;
  logic                    cmd_fire, in_fire, out_fire;

  assign cmd_fire = cmd_valid && cmd_ready;
  assign in_fire  = in_valid && in_ready;
  assign out_fire = out_valid && out_ready;

  ub_addr_seq #(
    .BUFFER_SIZE (BUFFER_SIZE),
    .ADDRESS_SIZE(ADDRESS_SIZE)
  ) u_seq (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (cmd_fire),
    .adv        (in_fire || out_fire),
    .base_in    (cmd_base),
    .words_in   (cmd_words),
    .addr       (seq_addr),
    .section    (seq_sec),
    .addr_nxt   (seq_addr_nxt),
    .section_nxt(seq_sec_nxt),
    .last       (seq_last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (cmd_fire) begin
          if (cmd_words == '0)              state_nxt = ST_FINISH;
          else if (cmd_dir == UB_DIR_LOAD)  state_nxt = ST_LOAD;
          else                              state_nxt = ST_RD;
        end
      end
      ST_LOAD:   if (in_valid && seq_last) state_nxt = ST_FINISH;
      ST_RD:     state_nxt = ST_CAP;
      ST_CAP:    state_nxt = ST_OUT;
      ST_OUT:    if (out_ready) state_nxt = seq_last ? ST_FINISH : ST_RD;
      ST_FINISH: state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    cmd_ready = (state == ST_IDLE);
    busy      = (state != ST_IDLE);
    in_ready  = (state == ST_LOAD);
    out_valid = (state == ST_OUT);
    cmd_done  = (state == ST_FINISH);
  end

  // Read strobes are launched on entry to RD using the sequencer's look-ahead
  // address, so ub_re is high during RD itself and data lands during CAP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ub_we      <= 1'b0;
      ub_re      <= 1'b0;
      ub_fifo_en <= 1'b0;
      ub_section <= 1'b0;
      ub_address <= '0;
      ub_fifo_in <= '0;
      out_data   <= '0;
    end else begin
      ub_we      <= 1'b0;
      ub_re      <= 1'b0;
      ub_fifo_en <= 1'b0;
      if (in_fire) begin
        ub_we      <= 1'b1;
        ub_fifo_en <= 1'b1;
        ub_address <= seq_addr;
        ub_section <= seq_sec;
        ub_fifo_in <= in_data;
      end else if (state_nxt == ST_RD) begin
        ub_re      <= 1'b1;
        ub_fifo_en <= 1'b1;
        ub_address <= seq_addr_nxt;
        ub_section <= seq_sec_nxt;
      end
      if (state == ST_CAP) out_data <= ub_fifo_out;
    end
  end

endmodule

// File: tb/tb_ub_fifo_bridge.sv
// Scoreboard bench for ub_fifo_bridge: drivers push expected writes/reads/bytes,
// a negedge monitor pops and compares whatever the DUT presents.
module tb_ub_fifo_bridge;

  localparam int BS = 1024;
  localparam int AW = 10;
  localparam int DW = 8;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cmd_valid = 1'b0, cmd_ready, cmd_dir = 1'b0, cmd_done, busy;
  logic [AW-1:0] cmd_base = '0;
  logic [AW:0]   cmd_words = '0;
  logic in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0;
  logic [DW-1:0] in_data = '0, out_data;
  logic ub_we, ub_re, ub_fifo_en, ub_section;
  logic [AW-1:0] ub_address;
  logic [DW-1:0] ub_fifo_in;
  logic [DW-1:0] ub_fifo_out = '0;

  always #5 clk = ~clk;

  ub_fifo_bridge #(.BUFFER_SIZE(BS), .FIFO_DATA_WIDTH(DW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_dir(cmd_dir),
    .cmd_base(cmd_base), .cmd_words(cmd_words), .cmd_done(cmd_done), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ub_we(ub_we), .ub_re(ub_re), .ub_fifo_en(ub_fifo_en), .ub_section(ub_section),
    .ub_address(ub_address), .ub_fifo_in(ub_fifo_in), .ub_fifo_out(ub_fifo_out)
  );

  // Buffer model driven by the DUT; ref_mem is the bench's own view of contents.
  logic [15:0] mem [BS];
  logic [15:0] ref_mem [BS];

  always @(posedge clk) begin
    if (ub_re) ub_fifo_out <= ub_section ? mem[ub_address][15:8] : mem[ub_address][7:0];
    if (ub_we) begin
      if (ub_section) mem[ub_address][15:8] <= ub_fifo_in;
      else            mem[ub_address][7:0]  <= ub_fifo_in;
    end
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct { int c; logic [AW-1:0] a; logic s; logic [7:0] d; } wr_t;
  typedef struct { logic [AW-1:0] a; logic s; } rd_t;
  wr_t        exp_wr[$];
  rd_t        exp_rd[$];
  logic [7:0] exp_out[$];
  logic [7:0] bq[$];

  int tests = 0, fails = 0;
  int done_cnt = 0, exp_done = 0, done_cyc = -1;
  int wr_cnt = 0, rd_cnt = 0, acc_cyc = 0;
  logic cur_dir = 1'b0;
  int   cur_words = 0;
  logic prev_done = 1'b0, prev_ov = 1'b0, prev_or = 1'b0;
  logic [7:0] prev_od = '0;
  wr_t ew;
  rd_t er;
  logic [7:0] eo;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_done = 1'b0; prev_ov = 1'b0; prev_or = 1'b0;
    end else begin
      if (ub_we || ub_re) chk("we_re_excl", 32'(ub_we & ub_re), 0);
      if (ub_we || ub_re || ub_fifo_en) chk("fifo_en", 32'(ub_fifo_en), 32'(ub_we | ub_re));
      if (ub_we) begin
        wr_cnt++;
        chk("wr_expected", 32'(exp_wr.size() != 0), 1);
        if (exp_wr.size() != 0) begin
          ew = exp_wr.pop_front();
          chk("wr_addr", 32'(ub_address), 32'(ew.a));
          chk("wr_sec", 32'(ub_section), 32'(ew.s));
          chk("wr_data", 32'(ub_fifo_in), 32'(ew.d));
          chk("wr_cycle", cyc, ew.c);
        end
      end
      if (ub_re) begin
        rd_cnt++;
        chk("rd_expected", 32'(exp_rd.size() != 0), 1);
        if (exp_rd.size() != 0) begin
          er = exp_rd.pop_front();
          chk("rd_addr", 32'(ub_address), 32'(er.a));
          chk("rd_sec", 32'(ub_section), 32'(er.s));
        end
      end
      if (out_valid) begin
        if (prev_ov && !prev_or) chk("out_stable", 32'(out_data), 32'(prev_od));
        if (out_ready) begin
          chk("out_expected", 32'(exp_out.size() != 0), 1);
          if (exp_out.size() != 0) begin
            eo = exp_out.pop_front();
            chk("out_data", 32'(out_data), 32'(eo));
          end
        end
      end
      if (cmd_done) begin
        chk("done_pulse", 32'(prev_done), 0);
        done_cnt++;
        done_cyc = cyc;
        if (cur_dir == 1'b0 && cur_words > 0) chk("we_at_done", 32'(ub_we), 1);
      end
      prev_done = cmd_done; prev_ov = out_valid; prev_or = out_ready; prev_od = out_data;
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  function automatic int sat(input int w);
    return (w > BS) ? BS : w;
  endfunction

  task automatic check_reset_outs(input string tag);
    chk({tag, "_strobes"}, 32'({ub_we, ub_re, ub_fifo_en, ub_section}), 0);
    chk({tag, "_addr"}, 32'(ub_address), 0);
    chk({tag, "_wdata"}, 32'(ub_fifo_in), 0);
    chk({tag, "_ctl"}, 32'({cmd_done, busy, in_ready, out_valid}), 0);
    chk({tag, "_out_data"}, 32'(out_data), 0);
    chk({tag, "_cmd_ready"}, 32'(cmd_ready), 1);
  endtask

  task automatic issue(input logic dir, input int base, input int words);
    int n = 0;
    while (!cmd_ready && n < 50) begin tick(); n++; end
    chk("cmd_ready", 32'(cmd_ready), 1);
    cmd_valid = 1'b1; cmd_dir = dir; cmd_base = AW'(base); cmd_words = (AW+1)'(words);
    cur_dir = dir; cur_words = words; acc_cyc = cyc; exp_done++;
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while (done_cnt < exp_done && n < bound) begin tick(); n++; end
    chk("done_count", done_cnt, exp_done);
    chk("ready_after_done", 32'(cmd_ready), 1);
    chk("done_to_ready", cyc, done_cyc + 1);
  endtask

  // Sends nsend bytes of bq; waits for completion only if the command is fully fed.
  task automatic load_cmd(input int base, input int words, input int nsend, input bit gaps);
    int n, g, w, last_acc;
    wr_t e;
    issue(1'b0, base, words);
    last_acc = cyc;
    for (int i = 0; i < nsend; i++) begin
      g = gaps ? ((i == 1) ? 2 : int'($urandom_range(0, 2))) : 0;
      repeat (g) begin in_valid = 1'b0; tick(); end
      in_valid = 1'b1; in_data = bq[i];
      n = 0;
      while (!in_ready && n < 20) begin tick(); n++; end
      chk("in_ready", 32'(in_ready), 1);
      w = (base + i / 2) % BS;
      e.c = cyc + 1; e.a = AW'(w); e.s = i[0]; e.d = bq[i];
      exp_wr.push_back(e);
      if (i[0]) ref_mem[w][15:8] = bq[i];
      else      ref_mem[w][7:0]  = bq[i];
      last_acc = cyc;
      tick();
    end
    in_valid = 1'b0;
    if (nsend == 2 * sat(words)) begin
      wait_done(20);
      chk("load_done_lat", done_cyc, last_acc + 1);
    end
  endtask

  task automatic drain_cmd(input int base, input int words, input int stall_idx,
                           input int stall_len, input bit rnd);
    int n, st, w, nb, rd0, last_hs;
    rd_t r;
    nb = 2 * sat(words);
    for (int i = 0; i < nb; i++) begin
      w = (base + i / 2) % BS;
      r.a = AW'(w); r.s = i[0];
      exp_rd.push_back(r);
      exp_out.push_back(i[0] ? ref_mem[w][15:8] : ref_mem[w][7:0]);
    end
    rd0 = rd_cnt;
    issue(1'b1, base, words);
    last_hs = acc_cyc;
    for (int i = 0; i < nb; i++) begin
      n = 0;
      while (!out_valid && n < 20) begin tick(); n++; end
      chk("out_valid", 32'(out_valid), 1);
      chk(i == 0 ? "first_out_lat" : "byte_period", cyc, last_hs + 3);
      st = (i == stall_idx) ? stall_len : (rnd ? int'($urandom_range(0, 2)) : 0);
      repeat (st) tick();
      chk("out_valid_hold", 32'(out_valid), 1);
      out_ready = 1'b1;
      last_hs = cyc;
      tick();
      out_ready = 1'b0;
    end
    wait_done(20);
    chk("drain_done_lat", done_cyc, last_hs + 1);
    chk("read_count", rd_cnt - rd0, nb);
  endtask

  task automatic noop_cmd(input logic dir);
    int wr0 = wr_cnt, rd0 = rd_cnt;
    in_valid = 1'b1; in_data = 8'h5A;
    issue(dir, int'($urandom_range(0, BS - 1)), 0);
    chk("noop_in_ready", 32'(in_ready), 0);
    chk("noop_busy", 32'(busy), 1);
    wait_done(5);
    in_valid = 1'b0;
    chk("noop_done_lat", done_cyc, acc_cyc + 1);
    chk("noop_strobes", (wr_cnt - wr0) + (rd_cnt - rd0), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int wr0, words;
    for (int i = 0; i < BS; i++) begin
      mem[i] = 16'($urandom);
      ref_mem[i] = mem[i];
    end
    #1 check_reset_outs("por");
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    // Abandon a load after three bytes with an asynchronous reset.
    bq = '{8'h11, 8'h22, 8'h33, 8'h44};
    load_cmd(100, 4, 3, 1'b0);
    tick();
    #2 rst_n = 1'b0;
    exp_done--;
    #1 check_reset_outs("mid");
    tick(); tick();
    rst_n = 1'b1;
    wr0 = wr_cnt;
    in_valid = 1'b1; in_data = 8'hEE;
    repeat (6) tick();
    in_valid = 1'b0;
    chk("no_we_after_reset", wr_cnt, wr0);
    chk("wr_q_after_reset", exp_wr.size(), 0);

    // Directed load / drain of two words at base 5.
    bq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    wr0 = wr_cnt;
    load_cmd(5, 2, 4, 1'b1);
    chk("load_writes", wr_cnt - wr0, 4);
    drain_cmd(5, 2, 1, 4, 1'b0);

    // Wrap past the top of the buffer.
    bq = '{8'h01, 8'h02, 8'h03, 8'h04};
    load_cmd(BS - 1, 2, 4, 1'b1);
    drain_cmd(BS - 1, 2, -1, 0, 1'b1);

    noop_cmd(1'b0);
    noop_cmd(1'b1);

    for (int k = 0; k < 8; k++) begin
      words = int'($urandom_range(1, 5));
      if ($urandom_range(0, 1) == 0) begin
        bq.delete();
        for (int i = 0; i < 2 * words; i++) bq.push_back(8'($urandom));
        load_cmd(int'($urandom_range(0, BS - 1)), words, 2 * words, 1'b1);
      end else begin
        drain_cmd(int'($urandom_range(0, BS - 1)), words, -1, 0, 1'b1);
      end
    end

    // Oversized word count saturates to the whole buffer.
    drain_cmd(3, 2047, -1, 0, 1'b0);

    chk("wr_q_empty", exp_wr.size(), 0);
    chk("rd_q_empty", exp_rd.size(), 0);
    chk("out_q_empty", exp_out.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
